aemb_dwb_bridge: RTL

AEMB_DWB_BRIDGE -- requirements
Module: aemb_dwb_bridge

---
 rtl/aemb_dwb_bridge.sv | 112 +++++++++++
 1 files changed

// File: rtl/aemb_dwb_bridge.sv
// aemb_dwb_bridge: CPU data port to Wishbone classic bridge with retry, error and optional timeout handling.
// Define AEMB_DWB_TIMEOUT_EN to enable the TIMEOUT_CYCLES bus-cycle watchdog.
module aemb_dwb_bridge #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRY      = 3,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_adr_i,
    input  logic [31:0] cpu_dat_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic        cpu_wre_i,
    input  logic        cpu_stb_i,
    input  logic        cpu_cyc_i,
    output logic [31:0] cpu_dat_o,
    output logic        cpu_ack_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic        err_irq_o,
    output logic [31:0] err_adr_o
);
    typedef enum logic [2:0] {IDLE, BUS, BACKOFF, ACK, FAULT} state_t;
    state_t state, state_nx;
    logic [3:0] retry_cnt;
    logic       timeout;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range");
    end
    if (MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_bad_retry
        $error("MAX_RETRY out of range");
    end

`ifdef AEMB_DWB_TIMEOUT_EN
    logic [15:0] to_cnt;
    assign timeout = to_cnt >= 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            to_cnt <= '0;
        else if (state == IDLE || state_nx == BACKOFF)
            to_cnt <= '0;
        else if (state == BUS)
            to_cnt <= to_cnt + 16'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    // Outputs are decoded from the state register so reset drops them without waiting for an edge.
    assign wb_cyc_o  = state == BUS;
    assign wb_stb_o  = state == BUS;
    assign cpu_ack_o = state == ACK || state == FAULT;
    assign err_irq_o = state == FAULT;
    assign wb_cti_o  = 3'b000;
    assign wb_bte_o  = 2'b00;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (cpu_stb_i && cpu_cyc_i) ? BUS : IDLE;
            BUS:     state_nx = wb_err_i ? FAULT :
                                wb_ack_i ? ACK :
                                wb_rty_i ? ((retry_cnt < 4'(MAX_RETRY)) ? BACKOFF : FAULT) :
                                timeout  ? FAULT : BUS;
            BACKOFF: state_nx = BUS;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            retry_cnt <= '0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            wb_we_o   <= 1'b0;
            cpu_dat_o <= '0;
            err_adr_o <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == BUS) begin
                wb_adr_o  <= cpu_adr_i;
                wb_dat_o  <= cpu_dat_i;
                wb_sel_o  <= cpu_sel_i;
                wb_we_o   <= cpu_wre_i;
                retry_cnt <= '0;
            end
            if (state == BUS && state_nx == ACK && !wb_we_o)
                cpu_dat_o <= wb_dat_i;
            if (state == BUS && state_nx == BACKOFF)
                retry_cnt <= retry_cnt + 4'd1;
            // Fault data and address are loaded on entry so they are valid while FAULT pulses ack/irq.
            if (state == BUS && state_nx == FAULT) begin
                err_adr_o <= wb_adr_o;
                if (!wb_we_o)
                    cpu_dat_o <= ERR_DATA;
            end
        end
    end
endmodule
